// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (D).
// Optional UNIFIED_MEM_ARB_RR_EN selects round-robin instead of fixed D-over-IF priority.
module unified_mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          own_d_q, own_d_d;
  logic          we_q, we_d;
  logic          byte_q, byte_d;
  logic [1:0]    lane_q, lane_d;
  logic          grant_d;
  logic [AW-1:0] sel_addr;
  logic [7:0]    rd_byte;
  logic [DW-1:0] rd_steer;

  logic          mem_en_nx, mem_we_nx, if_done_nx, d_done_nx, busy_nx;
  logic [3:0]    mem_be_nx;
  logic [AW-1:0] mem_addr_nx;
  logic [DW-1:0] mem_wdata_nx, if_rdata_nx, d_rdata_nx;

`ifdef UNIFIED_MEM_ARB_RR_EN
  logic last_d_q;

  // Last owner resets to IF so that D wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_d_q <= 1'b0;
    else if (state_q == IDLE && (if_req || d_req))
      last_d_q <= grant_d;
  end

  assign grant_d = d_req && (!if_req || !last_d_q);
`else
  assign grant_d = d_req;
`endif

  assign sel_addr = grant_d ? d_addr : if_addr;
  assign rd_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
  assign rd_steer = byte_q ? {{(DW-8){rd_byte[7]}}, rd_byte} : mem_rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    own_d_d      = own_d_q;
    we_d         = we_q;
    byte_d       = byte_q;
    lane_d       = lane_q;
    mem_en_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    mem_be_nx    = 4'h0;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_rdata_nx  = if_rdata;
    d_rdata_nx   = d_rdata;
    if_done_nx   = 1'b0;
    d_done_nx    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d      = ACCESS;
          own_d_d      = grant_d;
          we_d         = grant_d & d_we;
          byte_d       = grant_d & d_byte;
          lane_d       = sel_addr[1:0];
          // Outputs are registered, so the ACCESS-cycle command is loaded here.
          mem_en_nx    = 1'b1;
          mem_we_nx    = grant_d & d_we;
          mem_be_nx    = (grant_d & d_byte) ? (4'b0001 << sel_addr[1:0]) : 4'hF;
          mem_addr_nx  = {sel_addr[AW-1:2], 2'b00};
          mem_wdata_nx = grant_d ? (d_byte ? {4{d_wdata[7:0]}} : d_wdata) : '0;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d   = RESP;
          d_done_nx = own_d_q;
          if_done_nx = !own_d_q;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(LAT);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          if (own_d_q) begin
            d_rdata_nx = rd_steer;
            d_done_nx  = 1'b1;
          end else begin
            if_rdata_nx = mem_rdata;
            if_done_nx  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_nx = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      own_d_q   <= 1'b0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      lane_q    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_d_q   <= own_d_d;
      we_q      <= we_d;
      byte_q    <= byte_d;
      lane_q    <= lane_d;
      mem_en    <= mem_en_nx;
      mem_we    <= mem_we_nx;
      mem_be    <= mem_be_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_rdata  <= if_rdata_nx;
      d_rdata   <= d_rdata_nx;
      if_done   <= if_done_nx;
      d_done    <= d_done_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected memory commands and done pulses are queued at issue time.
module tb_unified_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_byte = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = 32'hDEAD_0BAD;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_done, d_done, mem_en, mem_we, busy;
  logic [3:0]    mem_be;

  unified_mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct { logic is_d; logic chk_data; logic [31:0] data; int cyc; } resp_t;
  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; int cyc; } memx_t;
  resp_t       resp_q[$];
  memx_t       mem_q[$];
  logic [31:0] rd_word = '0;
  logic        last_d_model = 1'b0;

  // Memory model: read data valid only in the cycle exactly LAT after the mem_en cycle.
  always begin
    @(negedge clk);
    if (rst && mem_en && !mem_we) begin
      repeat (LAT) @(negedge clk);
      mem_rdata = rd_word;
      @(negedge clk);
      mem_rdata = 32'hDEAD_0BAD;
    end
  end

  always @(negedge clk) begin : monitor
    resp_t r;
    memx_t m;
    logic [31:0] got;
    if (rst) begin
      if (if_done || d_done) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d if_done=%b d_done=%b, required no pulse", cyc, if_done, d_done);
        end else begin
          r = resp_q.pop_front();
          got = r.is_d ? d_rdata : if_rdata;
          if ((if_done && d_done) || d_done !== r.is_d || cyc != r.cyc || (r.chk_data && got !== r.data)) begin
            errors++;
            $display("FAIL resp: if_done=%b d_done=%b cyc=%0d data=%h, required owner_d=%b cyc=%0d data=%h",
                     if_done, d_done, cyc, got, r.is_d, r.cyc, r.data);
          end
        end
      end
      if (mem_en) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_mem_en cyc=%0d addr=%h, required no access", cyc, mem_addr);
        end else begin
          m = mem_q.pop_front();
          if (mem_we !== m.we || mem_addr !== m.addr || cyc != m.cyc ||
              (m.we && (mem_be !== m.be || mem_wdata !== m.wdata))) begin
            errors++;
            $display("FAIL mem_cmd: we=%b be=%b addr=%h wdata=%h cyc=%0d, required we=%b be=%b addr=%h wdata=%h cyc=%0d",
                     mem_we, mem_be, mem_addr, mem_wdata, cyc, m.we, m.be, m.addr, m.wdata, m.cyc);
          end
        end
      end else begin
        checks++;
        if (mem_we !== 1'b0 || mem_be !== 4'h0) begin
          errors++;
          $display("FAIL idle_strobes cyc=%0d we=%b be=%b, required 0/0", cyc, mem_we, mem_be);
        end
      end
    end
  end

  function automatic int push_d(input logic we, input logic byt, input logic [31:0] addr,
                                input logic [31:0] wd, input int t);
    memx_t m;
    resp_t r;
    logic [31:0] b;
    m.we    = we;
    m.be    = byt ? (4'b0001 << addr[1:0]) : 4'hF;
    m.addr  = addr & 32'hFFFF_FFFC;
    m.wdata = byt ? {4{wd[7:0]}} : wd;
    m.cyc   = t + 1;
    mem_q.push_back(m);
    b = rd_word >> (8 * addr[1:0]);
    r.is_d     = 1'b1;
    r.chk_data = !we;
    r.data     = byt ? {{24{b[7]}}, b[7:0]} : rd_word;
    r.cyc      = t + (we ? 2 : LAT + 2);
    resp_q.push_back(r);
    return r.cyc + 1;
  endfunction

  function automatic int push_if(input logic [31:0] addr, input int t);
    memx_t m;
    resp_t r;
    m.we = 1'b0; m.be = 4'hF; m.addr = addr & 32'hFFFF_FFFC; m.wdata = '0; m.cyc = t + 1;
    mem_q.push_back(m);
    r.is_d = 1'b0; r.chk_data = 1'b1; r.data = rd_word; r.cyc = t + LAT + 2;
    resp_q.push_back(r);
    return r.cyc + 1;
  endfunction

  task automatic wait_dones(input int n, input logic drop_each, input string name);
    int seen = 0;
    int budget = 150;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (if_done || d_done) begin
        seen++;
        if (seen == n) begin
          if_req = 1'b0; d_req = 1'b0;
        end else if (drop_each) begin
          if (if_done) if_req = 1'b0;
          if (d_done)  d_req  = 1'b0;
        end
      end
    end
    checks++;
    if (seen < n) begin
      errors++;
      $display("FAIL %s timeout: %0d done pulses, required %0d", name, seen, n);
      if_req = 1'b0; d_req = 1'b0;
      resp_q.delete(); mem_q.delete();
    end
  endtask

  task automatic drive_d(input logic we, input logic byt, input logic [31:0] addr, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_byte = byt; d_addr = addr; d_wdata = wd;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({if_done, d_done, mem_en, mem_we, mem_be, busy} !== 9'h0 ||
        {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_values: done=%b%b en=%b we=%b be=%b busy=%b addr=%h, required all zero",
               if_done, d_done, mem_en, mem_we, mem_be, busy, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_if_read;
    int t, nt;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: busy=%b, required 0", busy); end
    rd_word = 32'h2402_0005; if_addr = 32'h0000_0010; if_req = 1'b1;
    t = cyc; nt = push_if(32'h0000_0010, t);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_access: busy=%b, required 1", busy); end
    wait_dones(1, 1'b0, "if_read");
  endtask

  task automatic test_d_ops;
    int t, nt;
    @(negedge clk); drive_d(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
    t = cyc; nt = push_d(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, t);
    wait_dones(1, 1'b0, "sw");
    @(negedge clk); drive_d(1'b1, 1'b1, 32'h43, 32'h0000_0080);
    t = cyc; nt = push_d(1'b1, 1'b1, 32'h43, 32'h0000_0080, t);
    wait_dones(1, 1'b0, "sb");
    @(negedge clk); rd_word = 32'h0000_F200; drive_d(1'b0, 1'b1, 32'h41, 32'h0);
    t = cyc; nt = push_d(1'b0, 1'b1, 32'h41, 32'h0, t);
    wait_dones(1, 1'b0, "lb_neg");
    @(negedge clk); rd_word = 32'h0000_7200; drive_d(1'b0, 1'b1, 32'h41, 32'h0);
    t = cyc; nt = push_d(1'b0, 1'b1, 32'h41, 32'h0, t);
    wait_dones(1, 1'b0, "lb_pos");
    @(negedge clk); rd_word = 32'h89AB_CDEF; drive_d(1'b0, 1'b0, 32'h46, 32'h0);
    t = cyc; nt = push_d(1'b0, 1'b0, 32'h46, 32'h0, t);
    wait_dones(1, 1'b0, "lw");
  endtask

  task automatic test_drop_and_change;
    int t, nt;
    @(negedge clk);
    rd_word = 32'hCAFE_F00D; if_addr = 32'h0000_0103; if_req = 1'b1;
    t = cyc; nt = push_if(32'h0000_0103, t);
    @(negedge clk);
    if_req = 1'b0; if_addr = 32'h0000_0200;
    wait_dones(1, 1'b0, "drop_req");
  endtask

  task automatic test_rst_mid;
    int t, nt;
    @(negedge clk);
    rd_word = 32'h1111_2222; if_addr = 32'h0000_0020; if_req = 1'b1;
    t = cyc; nt = push_if(32'h0000_0020, t);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({if_done, d_done, mem_en, mem_we, mem_be, busy} !== 9'h0 ||
        {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid_zero: done=%b%b en=%b busy=%b addr=%h rdata=%h, required all zero",
               if_done, d_done, mem_en, busy, mem_addr, if_rdata);
    end
    resp_q.delete();
    mem_q.delete();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    t = cyc; nt = push_if(32'h0000_0020, t);
    wait_dones(1, 1'b0, "rst_restart");
    last_d_model = 1'b0;
  endtask

  task automatic test_arb;
    int t, nt;
    @(negedge clk);
    rd_word = 32'h5555_AAAA; if_addr = 32'h0000_0030; if_req = 1'b1;
    drive_d(1'b1, 1'b0, 32'h80, 32'h1234_5678);
    t = cyc;
    nt = push_d(1'b1, 1'b0, 32'h80, 32'h1234_5678, t);
    nt = push_if(32'h0000_0030, nt);
    wait_dones(2, 1'b1, "arb_tie");
    last_d_model = 1'b0;
  endtask

  task automatic test_back_to_back;
    int t;
    logic g;
    @(negedge clk);
    rd_word = 32'h7777_0001; if_addr = 32'h0000_0050; if_req = 1'b1;
    drive_d(1'b1, 1'b0, 32'h90, 32'hA5A5_5A5A);
    t = cyc;
    for (int i = 0; i < 6; i++) begin
`ifdef UNIFIED_MEM_ARB_RR_EN
      g = !last_d_model;
`else
      g = 1'b1;
`endif
      if (g) t = push_d(1'b1, 1'b0, 32'h90, 32'hA5A5_5A5A, t);
      else   t = push_if(32'h0000_0050, t);
      last_d_model = g;
    end
    wait_dones(6, 1'b0, "back_to_back");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_if_read();
    test_d_ops();
    test_drop_and_change();
    test_rst_mid();
    test_arb();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (resp_q.size() != 0 || mem_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses and %0d accesses outstanding, required 0/0", resp_q.size(), mem_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
